// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - IF stage control, redirect, ROM and IF/ID bundle
interface fetch_stage_if;
  logic        stall;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic        jump_d;
  logic        take_d;
  logic [31:0] target_d;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_i;
  logic [31:0] pc8_i;
  logic        bd_i;
  logic [4:0]  exccode_i;
  logic [31:0] npcout;
  logic [31:0] pc;

  // master: the fetch stage itself; slave: pipeline, CP0 and ROM around it
  modport master (
    input  stall, exc_req, eret, epc, jump_d, take_d, target_d, imem_rdata,
    output imem_addr, instr_i, pc8_i, bd_i, exccode_i, npcout, pc
  );

  modport slave (
    output stall, exc_req, eret, epc, jump_d, take_d, target_d, imem_rdata,
    input  imem_addr, instr_i, pc8_i, bd_i, exccode_i, npcout, pc
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: PC register, next-PC select, ROM fetch, AdEL
// Optional fetch range check enabled by defining IF_RANGE_CHK_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
`ifdef IF_RANGE_CHK_EN
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IMEM_TOP   = 32'h0000_6FFC,
`endif
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_stage_if.master bus
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic        misaligned;
  logic        adel;

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;

  // Exception entry beats ERET, and both beat stall; branch only when free to move.
  always_comb begin
    pc_d = pc_plus4;
    if (bus.exc_req) begin
      pc_d = HANDLER_PC;
    end else if (bus.eret) begin
      pc_d = bus.epc;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.jump_d && bus.take_d) begin
      pc_d = bus.target_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign misaligned = (pc_q[1:0] != 2'b00);

`ifdef IF_RANGE_CHK_EN
  assign adel = misaligned || (pc_q < IMEM_BASE) || (pc_q > IMEM_TOP);
`else
  assign adel = misaligned;
`endif

  assign bus.pc        = pc_q;
  assign bus.imem_addr = pc_q;
  assign bus.pc8_i     = pc_plus8;
  assign bus.npcout    = pc_d;
  assign bus.instr_i   = adel ? 32'h0000_0000 : bus.imem_rdata;
  assign bus.exccode_i = adel ? EXC_ADEL : EXC_NONE;
  // A redirected fetch is never a delay slot; reset also forces it clear.
  assign bus.bd_i      = reset_n && bus.jump_d && !bus.exc_req && !bus.eret;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] m_pc;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_rdata = rom(bus.imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit exc, input bit er, input bit st, input bit jd,
                       input bit tk, input logic [31:0] tgt, input logic [31:0] ep);
    bus.exc_req  = exc;
    bus.eret     = er;
    bus.stall    = st;
    bus.jump_d   = jd;
    bus.take_d   = tk;
    bus.target_d = tgt;
    bus.epc      = ep;
  endtask

  // Drive one cycle, check the fetch-side outputs against the model pc,
  // push the predicted next pc and compare it after the clock edge.
  task automatic step(input string tag, input bit exc, input bit er, input bit st,
                      input bit jd, input bit tk, input logic [31:0] tgt,
                      input logic [31:0] ep);
    logic [31:0] e_npc;
    logic        e_adel;
    logic [31:0] got;
    drive(exc, er, st, jd, tk, tgt, ep);
    #1;
    if (exc)           e_npc = HANDLER_PC;
    else if (er)       e_npc = ep;
    else if (st)       e_npc = m_pc;
    else if (jd && tk) e_npc = tgt;
    else               e_npc = m_pc + 32'd4;
    e_adel = (m_pc[1:0] != 2'b00);
`ifdef IF_RANGE_CHK_EN
    if (m_pc < 32'h0000_3000 || m_pc > 32'h0000_6FFC) e_adel = 1'b1;
`endif
    chk({tag, ".imem_addr"}, bus.imem_addr, m_pc);
    chk({tag, ".pc8"},       bus.pc8_i, m_pc + 32'd8);
    chk({tag, ".bd"},        {31'd0, bus.bd_i}, {31'd0, jd & ~exc & ~er});
    chk({tag, ".exccode"},   {27'd0, bus.exccode_i}, e_adel ? 32'd4 : 32'd0);
    chk({tag, ".instr"},     bus.instr_i, e_adel ? 32'h0 : rom(m_pc));
    chk({tag, ".npcout"},    bus.npcout, e_npc);
    exp_q.push_back(e_npc);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      got  = exp_q.pop_front();
      m_pc = got;
      chk({tag, ".pc"}, bus.pc, got);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".pc"},        bus.pc, RESET_PC);
    chk({tag, ".imem_addr"}, bus.imem_addr, RESET_PC);
    chk({tag, ".pc8"},       bus.pc8_i, RESET_PC + 32'd8);
    chk({tag, ".bd"},        {31'd0, bus.bd_i}, 32'd0);
    chk({tag, ".exccode"},   {27'd0, bus.exccode_i}, 32'd0);
    chk({tag, ".instr"},     bus.instr_i, rom(RESET_PC));
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_5000, 32'h0000_3300);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset_n = 1'b1;
    m_pc = RESET_PC;
    #1;

    step("seq0", 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step("seq1", 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step("seq2", 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step("seq3", 0, 0, 0, 0, 1, 32'h0000_3F00, 32'h0);
    step("br",   0, 0, 0, 1, 1, 32'h0000_3100, 32'h0);
    step("post_br", 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step("jmp_3020", 0, 0, 0, 1, 1, 32'h0000_3020, 32'h0);
    step("stall0", 0, 0, 1, 0, 0, 32'h0, 32'h0);
    step("stall1", 0, 0, 1, 1, 1, 32'h0000_3500, 32'h0);
    step("stall2", 0, 0, 1, 0, 0, 32'h0, 32'h0);
    step("unstall", 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step("exc_all", 1, 1, 1, 1, 1, 32'h0000_3600, 32'h0000_3040);
    step("eret", 0, 1, 1, 1, 1, 32'h0000_3700, 32'h0000_3044);
    step("after_eret", 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step("to_3102", 0, 0, 0, 1, 1, 32'h0000_3102, 32'h0);
    step("adel_mis", 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step("to_7000", 0, 0, 0, 1, 1, 32'h0000_7000, 32'h0);
    step("at_7000", 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0);
    step("wrap", 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step("at_zero", 0, 0, 0, 0, 0, 32'h0, 32'h0);

    // asynchronous reset mid-cycle with redirects pending
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_5100, 32'h0000_5200);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_edge");
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset_n = 1'b1;
    m_pc = RESET_PC;
    #1;
    step("rel0", 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step("rel1", 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step("rel2", 0, 0, 0, 0, 0, 32'h0, 32'h0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
